// File: rtl/pc_fetch_control.sv
// Program-counter register and fetch sequencer: selects the next PC, runs the
// instruction-memory req/ack handshake and tags fetched words valid or squashed.
module pc_fetch_control #(
    parameter int unsigned            WIDTH    = 32,
    parameter logic [WIDTH-1:0]       RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             stall,
    input  logic             halt,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             instr_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pc_nx;
    logic             redir_pend, redir_pend_nx;
    logic [WIDTH-1:0] redir_pc, redir_pc_nx;
    logic [WIDTH-1:0] fetch_pc_nx;
    logic             instr_valid_nx;

    logic             redir_now;
    logic [WIDTH-1:0] redir_tgt;

    // Jump has priority over a taken branch.
    assign redir_now = jump | branch_taken;
    assign redir_tgt = jump ? jump_target : branch_target;

    // Handshake and status outputs decode directly from the state register.
    assign imem_req  = (state == FETCH);
    assign halted    = (state == HALTED);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redir_pend  <= 1'b0;
            redir_pc    <= '0;
            fetch_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            redir_pend  <= redir_pend_nx;
            redir_pc    <= redir_pc_nx;
            fetch_pc    <= fetch_pc_nx;
            instr_valid <= instr_valid_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        redir_pend_nx  = redir_pend;
        redir_pc_nx    = redir_pc;
        fetch_pc_nx    = fetch_pc;
        instr_valid_nx = 1'b0;

        case (state)
            IDLE: begin
                if (halt) begin
                    state_nx = HALTED;
                end else if (redir_now) begin
                    pc_nx = redir_tgt;
                    if (!stall) begin
                        state_nx = FETCH;
                    end
                end else if (!stall) begin
                    state_nx = FETCH;
                end
            end

            FETCH: begin
                if (imem_ack) begin
                    fetch_pc_nx    = pc;
                    // A redirect seen during this fetch means the word is wrong-path.
                    instr_valid_nx = ~(redir_pend | redir_now);
                    redir_pend_nx  = 1'b0;
                    if (redir_now) begin
                        pc_nx = redir_tgt;
                    end else if (redir_pend) begin
                        pc_nx = redir_pc;
                    end else begin
                        pc_nx = pc_plus1;
                    end
                    if (halt) begin
                        state_nx = HALTED;
                    end else if (stall) begin
                        state_nx = IDLE;
                    end
                end else if (redir_now) begin
                    // Address must stay stable until ack, so park the redirect.
                    redir_pend_nx = 1'b1;
                    redir_pc_nx   = redir_tgt;
                end
            end

            HALTED: begin
                state_nx = HALTED;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed bench for pc_fetch_control: stimulus pushes expected handshake
// addresses and valid fetch PCs; a negedge monitor pops and compares them.
module tb_pc_fetch_control;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             stall;
    logic             halt;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic             instr_valid;
    logic [WIDTH-1:0] fetch_pc;
    logic             halted;

    int total  = 0;
    int passed = 0;

    logic [WIDTH-1:0] exp_addr[$];
    logic [WIDTH-1:0] exp_fetch[$];

    pc_fetch_control #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .fetch_pc      (fetch_pc),
        .halted        (halted)
    );

    // External incrementer; 32-bit arithmetic wraps naturally.
    assign pc_plus1 = pc + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake and every valid instruction is scored.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (!reset && imem_req && imem_ack) begin
            if (exp_addr.size() == 0) begin
                total++;
                $display("FAIL hs_unexpected: got addr %h expected none", imem_addr);
            end else begin
                e = exp_addr.pop_front();
                check("hs_addr", imem_addr, e);
            end
        end
        if (instr_valid) begin
            if (exp_fetch.size() == 0) begin
                total++;
                $display("FAIL valid_unexpected: got fetch_pc %h expected none", fetch_pc);
            end else begin
                e = exp_fetch.pop_front();
                check("fetch_pc", fetch_pc, e);
            end
        end
    end

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
        jump_target = '0; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_fetch_pc", fetch_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // Sequential fetch, ack held high; stall raised at the last ack.
        reset = 1'b0; imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(i));
            exp_fetch.push_back(32'(i));
        end
        tick();
        check("idle_then_fetch_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("seq_req", 32'(imem_req), 32'h1);
            if (i == 3) stall = 1'b1;
            tick();
            check("seq_valid", 32'(instr_valid), 32'h1);
        end
        check("stall_req", 32'(imem_req), 32'h0);
        check("stall_pc", pc, 32'h4);
        tick(); tick();
        check("stall_pc_frozen", pc, 32'h4);
        check("stall_req_low", 32'(imem_req), 32'h0);

        // Release stall: resume at 4, then slow memory for 5.
        imem_ack = 1'b0; stall = 1'b0;
        tick();
        check("resume_addr", imem_addr, 32'h4);
        imem_ack = 1'b1; exp_addr.push_back(32'h4); exp_fetch.push_back(32'h4);
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("slow_addr_held", imem_addr, 32'h5);
            tick();
        end
        imem_ack = 1'b1; exp_addr.push_back(32'h5); exp_fetch.push_back(32'h5);
        tick();
        imem_ack = 1'b0;
        check("slow_next_addr", imem_addr, 32'h6);
        tick();
        check("slow_single_pulse", 32'(instr_valid), 32'h0);

        // Jump with ack squashes 6 and goes to 0x10.
        jump = 1'b1; jump_target = 32'h10; imem_ack = 1'b1; exp_addr.push_back(32'h6);
        tick();
        jump = 1'b0; imem_ack = 1'b0;
        check("jump_squash", 32'(instr_valid), 32'h0);
        check("jump_addr", imem_addr, 32'h10);
        tick();
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0; imem_ack = 1'b1; exp_addr.push_back(32'h10);
        check("pend_addr_held", imem_addr, 32'h10);
        tick();
        check("pend_squash", 32'(instr_valid), 32'h0);
        check("pend_redirect_addr", imem_addr, 32'h40);

        // Jump and branch together: jump target wins.
        jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h90;
        exp_addr.push_back(32'h40);
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        check("jump_beats_branch", imem_addr, 32'h80);
        exp_addr.push_back(32'h80); exp_fetch.push_back(32'h80);
        tick();
        jump = 1'b1; jump_target = 32'h20; exp_addr.push_back(32'h81);
        tick();
        jump = 1'b0; imem_ack = 1'b0; halt = 1'b1;

        // Halt during FETCH at 0x20 waits for the ack.
        tick();
        check("halt_waits_req", 32'(imem_req), 32'h1);
        check("halt_waits_halted", 32'(halted), 32'h0);
        check("halt_addr", imem_addr, 32'h20);
        imem_ack = 1'b1; exp_addr.push_back(32'h20); exp_fetch.push_back(32'h20);
        tick();
        check("halted_set", 32'(halted), 32'h1);
        check("halted_req", 32'(imem_req), 32'h0);
        halt = 1'b0; jump = 1'b1; jump_target = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_stays", 32'(halted), 32'h1);
            check("halted_pc", pc, 32'h21);
        end
        jump = 1'b0; imem_ack = 1'b0; reset = 1'b1;
        tick();
        check("halt_reset_pc", pc, 32'h0);
        check("halt_reset_halted", 32'(halted), 32'h0);

        // Wrap from 0xFFFF_FFFF to 0, then reset mid-FETCH.
        reset = 1'b0; jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
        imem_ack = 1'b1; exp_addr.push_back(32'hFFFF_FFFF); exp_fetch.push_back(32'hFFFF_FFFF);
        tick();
        check("wrap_addr_zero", imem_addr, 32'h0);
        exp_addr.push_back(32'h0); exp_fetch.push_back(32'h0);
        tick();
        check("pre_reset_addr", imem_addr, 32'h1);
        imem_ack = 1'b0; reset = 1'b1;
        tick();
        check("midfetch_reset_pc", pc, 32'h0);
        check("midfetch_reset_req", 32'(imem_req), 32'h0);
        check("midfetch_reset_valid", 32'(instr_valid), 32'h0);
        reset = 1'b0; stall = 1'b1;
        tick();
        check("addr_queue_drained", 32'(exp_addr.size()), 32'h0);
        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog against an unexpected stall of the stimulus process.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
